game_flow_ctrl: RTL and testbench
=================================

# game_flow_ctrl

Game-flow sequencer for the hundred-floors game. It owns the run/pause/respawn/game-over state machine and generates the speed-selected scroll tick that paces the playfield datapath. It also tracks lives and floors passed, and issues one-cycle sound-event requests. It sits between the synchronised reset/buttons and the main game datapath, and its outputs drive datapath enable, playfield clear, the score display and the buzzer logic.

## Interface
Parameters:
- TICK_DIV, 6_250_000: clk_50m cycles per scroll tick at sw=0 (8 Hz).
- RESPAWN_CYCLES, 25_000_000: length of the RESPAWN state (0.5 s).
- LIVES, 3: lives at game start (1..3).
- CNT_W, 25: width of the shared cycle counter. Must hold max(TICK_DIV, RESPAWN_CYCLES).

Ports:
- clk_50m  in  1  system clock, 50 MHz; only clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  debounced start button, level; acts on rising edge.
- pause  in  1  pause switch, level.
- sw  in  2  speed select; tick period = max(1, TICK_DIV >> sw).
- hit_spike  in  1  1-cycle pulse, player damaged.
- fell_out  in  1  1-cycle pulse, player left screen bottom; kills regardless of lives.
- floor_passed  in  1  1-cycle pulse, player landed on a new floor.
- state  out  3  IDLE=0, PLAY=1, PAUSED=2, RESPAWN=3, OVER=4, WIN=5.
- run_en  out  1  high only in PLAY.
- scroll_tick  out  1  1-cycle pulse, advance playfield.
- clear_field  out  1  1-cycle pulse, reinitialise playfield.
- lives  out  2  remaining lives.
- floor_cnt  out  7  floors passed, 0..100.
- snd_req  out  2  1-cycle event code: 0 none, 1 hurt, 2 death, 3 win.

## Operation
- Start edge = start & ~start_q. start_q resets to 1, so a button held through reset never starts a game.
- IDLE, OVER, WIN: a start edge goes to PLAY and pulses clear_field. It also loads lives=LIVES, sets floor_cnt=0 and clears the counter. All other inputs are ignored.
- PLAY: events are evaluated once per cycle in priority order fell_out > hit_spike > floor_passed > pause. Only the highest-priority event present acts.
  - fell_out: lives→0, snd_req=2, go to OVER.
  - hit_spike, lives>1: lives−1, snd_req=1, go to RESPAWN, clear the counter.
  - hit_spike, lives==1: lives→0, snd_req=2, go to OVER.
  - floor_passed: floor_cnt+1. If the result is 100, snd_req=3 and go to WIN.
  - pause=1: go to PAUSED; the counter freezes.
  - Scroll counter: increments each PLAY cycle. When cnt ≥ period−1, scroll_tick=1 and cnt→0. Using ≥ means a speed change that shrinks the period below cnt fires the tick on the next cycle.
  - On a cycle that leaves PLAY, no tick is issued.
- PAUSED: counter, lives and floor_cnt hold. hit_spike, fell_out, floor_passed and start are ignored. pause=0 returns to PLAY and counting resumes from the frozen value.
- RESPAWN: run_en=0, no ticks, and all events and pause are ignored. The counter counts to RESPAWN_CYCLES−1. At that point it goes to PLAY, pulses clear_field and clears the counter. floor_cnt is retained.
- floor_cnt saturates at 100. lives never underflows.

## Timing
- All outputs are registered. An input sampled at edge N produces its state/lives/floor_cnt/snd_req/clear_field change visible after edge N+1 (1-cycle latency).
- run_en is decoded from the registered state and is high exactly while state==PLAY.
- clear_field and snd_req are high for exactly one cycle, coincident with the first cycle of the new state.
- scroll_tick is high for one cycle every period cycles of uninterrupted PLAY. The first tick after entering PLAY from a cleared counter comes period cycles after entry.
- Reset values: state=IDLE, run_en=0, scroll_tick=0, clear_field=0, snd_req=0, lives=LIVES, floor_cnt=0, counter=0, start_q=1.
- Reset mid-game has the same result as power-up; no pulse outputs are emitted during or on exit from reset.

## Test plan
All scenarios use TICK_DIV=8, RESPAWN_CYCLES=4, LIVES=3.
- Reset, start pulse → state=1 next cycle; clear_field 1 cycle; lives=3; scroll_tick every 8 cycles with sw=0, every 4 with sw=1, every cycle with sw=3.
- In PLAY, hit_spike three times, each after respawn completes → snd_req 1,1,2; state 3 for 4 cycles then 1 with clear_field, twice; final state=4, lives=0, run_en=0.
- Pause when cnt=5 and hold 20 cycles while pulsing hit_spike → no ticks, lives unchanged. Release → next tick exactly 3 cycles after state returns to 1.
- 100 floor_passed pulses → floor_cnt=100, state=5, snd_req=3 once. A further floor_passed leaves floor_cnt=100. A start edge then gives state=1, floor_cnt=0.
- Same cycle fell_out+floor_passed+pause in PLAY with lives=3 → state=4, floor_cnt unchanged, snd_req=2, lives=0.
- Hold start high across reset release → state stays 0 until start drops and rises again, then goes to PLAY.

Source files
------------

// File: rtl/game_flow_ctrl.sv
// Game-flow sequencer for the hundred-floors game: run/pause/respawn/over/win FSM,
// speed-selected scroll tick, lives and floor tracking, one-cycle sound requests.
module game_flow_ctrl #(
  parameter int TICK_DIV       = 6_250_000,
  parameter int RESPAWN_CYCLES = 25_000_000,
  parameter int LIVES          = 3,
  parameter int CNT_W          = 25
) (
  input  logic       clk_50m,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  input  logic [1:0] sw,
  input  logic       hit_spike,
  input  logic       fell_out,
  input  logic       floor_passed,
  output logic [2:0] state,
  output logic       run_en,
  output logic       scroll_tick,
  output logic       clear_field,
  output logic [1:0] lives,
  output logic [6:0] floor_cnt,
  output logic [1:0] snd_req
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PLAY    = 3'd1,
    S_PAUSED  = 3'd2,
    S_RESPAWN = 3'd3,
    S_OVER    = 3'd4,
    S_WIN     = 3'd5
  } state_t;

  localparam logic [1:0]       SND_NONE   = 2'd0;
  localparam logic [1:0]       SND_HURT   = 2'd1;
  localparam logic [1:0]       SND_DEATH  = 2'd2;
  localparam logic [1:0]       SND_WIN    = 2'd3;
  localparam logic [6:0]       FLOOR_MAX  = 7'd100;
  localparam logic [1:0]       LIVES_INIT = 2'(LIVES);
  localparam logic [CNT_W-1:0] TICK_DIV_W = CNT_W'(TICK_DIV);
  localparam logic [CNT_W-1:0] RESP_LAST  = CNT_W'(RESPAWN_CYCLES - 1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt;
  logic             start_q;
  logic             start_edge;
  logic [CNT_W-1:0] period_raw;
  logic [CNT_W-1:0] period_m1;
  logic             tick_due;
  logic             floor_win;
  logic             play_stays;

  assign state  = state_q;
  assign run_en = (state_q == S_PLAY);

  // start_q resets high so a button held through reset is not seen as an edge.
  assign start_edge = start & ~start_q;

  // A zero period (TICK_DIV >> sw underflowing) behaves as period 1: tick every cycle.
  assign period_raw = TICK_DIV_W >> sw;
  assign period_m1  = (period_raw == '0) ? '0 : period_raw - CNT_W'(1);
  assign tick_due   = (cnt >= period_m1);

  // Leaving PLAY this cycle suppresses the tick and freezes the counter.
  always_comb begin
    floor_win  = 1'b0;
    play_stays = 1'b0;
    floor_win  = floor_passed && (floor_cnt == FLOOR_MAX - 7'd1);
    play_stays = !fell_out && !hit_spike && !floor_win && !(pause && !floor_passed);
  end

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt         <= '0;
      start_q     <= 1'b1;
      scroll_tick <= 1'b0;
      clear_field <= 1'b0;
      snd_req     <= SND_NONE;
      lives       <= LIVES_INIT;
      floor_cnt   <= '0;
    end else begin
      start_q     <= start;
      scroll_tick <= 1'b0;
      clear_field <= 1'b0;
      snd_req     <= SND_NONE;
      case (state_q)
        S_IDLE, S_OVER, S_WIN: begin
          if (start_edge) begin
            state_q     <= S_PLAY;
            clear_field <= 1'b1;
            lives       <= LIVES_INIT;
            floor_cnt   <= '0;
            cnt         <= '0;
          end
        end
        S_PLAY: begin
          if (fell_out) begin
            lives   <= 2'd0;
            snd_req <= SND_DEATH;
            state_q <= S_OVER;
          end else if (hit_spike) begin
            if (lives > 2'd1) begin
              lives   <= lives - 2'd1;
              snd_req <= SND_HURT;
              state_q <= S_RESPAWN;
              cnt     <= '0;
            end else begin
              lives   <= 2'd0;
              snd_req <= SND_DEATH;
              state_q <= S_OVER;
            end
          end else if (floor_passed) begin
            if (floor_win) begin
              floor_cnt <= FLOOR_MAX;
              snd_req   <= SND_WIN;
              state_q   <= S_WIN;
            end else if (floor_cnt < FLOOR_MAX) begin
              floor_cnt <= floor_cnt + 7'd1;
            end
          end else if (pause) begin
            state_q <= S_PAUSED;
          end
          if (play_stays) begin
            if (tick_due) begin
              scroll_tick <= 1'b1;
              cnt         <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        S_PAUSED: begin
          if (!pause) state_q <= S_PLAY;
        end
        S_RESPAWN: begin
          if (cnt >= RESP_LAST) begin
            state_q     <= S_PLAY;
            clear_field <= 1'b1;
            cnt         <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl; expected output vectors are queued when each
// stimulus step is driven and compared one cycle later.
module tb_game_flow_ctrl;

  localparam int W = 17;
  localparam logic [W-1:0] M_ALL    = 17'h1FFFF;
  localparam logic [W-1:0] M_NOTICK = 17'h1EFFF;

  logic       clk_50m = 1'b0;
  logic       rst, start, pause, hit_spike, fell_out, floor_passed;
  logic [1:0] sw;
  logic [2:0] state;
  logic       run_en, scroll_tick, clear_field;
  logic [1:0] lives, snd_req;
  logic [6:0] floor_cnt;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] msk_q[$];
  int total = 0;
  int bad   = 0;

  game_flow_ctrl #(.TICK_DIV(8), .RESPAWN_CYCLES(4), .LIVES(3), .CNT_W(8)) dut (
    .clk_50m(clk_50m), .rst(rst), .start(start), .pause(pause), .sw(sw),
    .hit_spike(hit_spike), .fell_out(fell_out), .floor_passed(floor_passed),
    .state(state), .run_en(run_en), .scroll_tick(scroll_tick),
    .clear_field(clear_field), .lives(lives), .floor_cnt(floor_cnt), .snd_req(snd_req)
  );

  // Clock / reset
  always #5 clk_50m = ~clk_50m;

  // Packed layout: state[16:14] run_en[13] tick[12] clear[11] lives[10:9] floor[8:2] snd[1:0]
  function automatic logic [W-1:0] pk(input int st, input int run, input int tk,
                                      input int clr, input int lv, input int fl, input int snd);
    return {st[2:0], run[0], tk[0], clr[0], lv[1:0], fl[6:0], snd[1:0]};
  endfunction

  task automatic check(input string tag);
    logic [W-1:0] o, e, m;
    o = {state, run_en, scroll_tick, clear_field, lives, floor_cnt, snd_req};
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL %s: expected queue empty, observed=%h", tag, o);
    end else begin
      e = exp_q.pop_front();
      m = msk_q.pop_front();
      assert ((o & m) === (e & m)) else begin
        bad++;
        $error("FAIL %s: observed=%h expected=%h (mask %h)", tag, o & m, e & m, m);
      end
    end
  endtask

  // Driver: queue expectation, advance one edge, sample 1 ns after it.
  task automatic cyc(input logic [W-1:0] e, input logic [W-1:0] m, input string tag);
    exp_q.push_back(e);
    msk_q.push_back(m);
    @(posedge clk_50m);
    #1;
    check(tag);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pause = 1'b0; sw = 2'd0;
    hit_spike = 1'b0; fell_out = 1'b0; floor_passed = 1'b0;

    cyc(pk(0,0,0,0,3,0,0), M_ALL, "reset0");
    cyc(pk(0,0,0,0,3,0,0), M_ALL, "reset1");
    rst = 1'b0;
    cyc(pk(0,0,0,0,3,0,0), M_ALL, "idle");

    // Start and tick periods for sw=0,1,3
    start = 1'b1;
    cyc(pk(1,1,0,1,3,0,0), M_ALL, "start_play");
    start = 1'b0;
    for (int k = 1; k <= 16; k++) cyc(pk(1,1,(k % 8 == 0),0,3,0,0), M_ALL, $sformatf("sw0_k%0d", k));
    sw = 2'd1;
    for (int k = 1; k <= 8; k++) cyc(pk(1,1,(k % 4 == 0),0,3,0,0), M_ALL, $sformatf("sw1_k%0d", k));
    sw = 2'd3;
    for (int k = 1; k <= 4; k++) cyc(pk(1,1,1,0,3,0,0), M_ALL, $sformatf("sw3_k%0d", k));
    sw = 2'd0;

    // Three hits: two respawns, then game over
    for (int h = 1; h <= 2; h++) begin
      hit_spike = 1'b1;
      cyc(pk(3,0,0,0,3-h,0,1), M_ALL, $sformatf("hit%0d", h));
      hit_spike = 1'b0;
      for (int k = 1; k <= 3; k++) cyc(pk(3,0,0,0,3-h,0,0), M_ALL, $sformatf("respawn%0d_k%0d", h, k));
      cyc(pk(1,1,0,1,3-h,0,0), M_ALL, $sformatf("respawn%0d_done", h));
    end
    hit_spike = 1'b1;
    cyc(pk(4,0,0,0,0,0,2), M_ALL, "hit3_over");
    hit_spike = 1'b0;
    cyc(pk(4,0,0,0,0,0,0), M_ALL, "over_hold");
    hit_spike = 1'b1; floor_passed = 1'b1;
    cyc(pk(4,0,0,0,0,0,0), M_ALL, "over_ignores");
    hit_spike = 1'b0; floor_passed = 1'b0;

    // Pause at cnt=5, hold 20 cycles with events, resume
    start = 1'b1;
    cyc(pk(1,1,0,1,3,0,0), M_ALL, "restart_over");
    start = 1'b0;
    for (int k = 1; k <= 5; k++) cyc(pk(1,1,0,0,3,0,0), M_ALL, $sformatf("pre_pause_k%0d", k));
    pause = 1'b1;
    cyc(pk(2,0,0,0,3,0,0), M_ALL, "pause_enter");
    for (int i = 0; i < 20; i++) begin
      hit_spike    = (i % 2 == 1);
      fell_out     = (i == 7);
      floor_passed = (i == 10);
      start        = (i == 12);
      cyc(pk(2,0,0,0,3,0,0), M_ALL, $sformatf("paused_i%0d", i));
    end
    hit_spike = 1'b0; fell_out = 1'b0; floor_passed = 1'b0; start = 1'b0; pause = 1'b0;
    cyc(pk(1,1,0,0,3,0,0), M_ALL, "resume");
    cyc(pk(1,1,0,0,3,0,0), M_ALL, "resume_k1");
    cyc(pk(1,1,0,0,3,0,0), M_ALL, "resume_k2");
    cyc(pk(1,1,1,0,3,0,0), M_ALL, "resume_tick_k3");

    // 100 floors -> WIN
    for (int i = 1; i <= 99; i++) begin
      floor_passed = 1'b1;
      cyc(pk(1,1,0,0,3,i,0), M_NOTICK, $sformatf("floor%0d", i));
      floor_passed = 1'b0;
      cyc(pk(1,1,0,0,3,i,0), M_NOTICK, $sformatf("floor%0d_gap", i));
    end
    floor_passed = 1'b1;
    cyc(pk(5,0,0,0,3,100,3), M_ALL, "win");
    floor_passed = 1'b0;
    cyc(pk(5,0,0,0,3,100,0), M_ALL, "win_hold");
    floor_passed = 1'b1;
    cyc(pk(5,0,0,0,3,100,0), M_ALL, "win_extra_floor");
    floor_passed = 1'b0;
    start = 1'b1;
    cyc(pk(1,1,0,1,3,0,0), M_ALL, "restart_win");
    start = 1'b0;

    // Simultaneous fell_out + floor_passed + pause
    floor_passed = 1'b1;
    cyc(pk(1,1,0,0,3,1,0), M_NOTICK, "floor_before_fall");
    fell_out = 1'b1; pause = 1'b1;
    cyc(pk(4,0,0,0,0,1,2), M_ALL, "fell_priority");
    fell_out = 1'b0; pause = 1'b0; floor_passed = 1'b0;
    cyc(pk(4,0,0,0,0,1,0), M_ALL, "fell_snd_once");

    // Mid-game reset with start held through release
    start = 1'b1;
    cyc(pk(1,1,0,1,3,0,0), M_ALL, "play_before_reset");
    floor_passed = 1'b1;
    cyc(pk(1,1,0,0,3,1,0), M_NOTICK, "floor_before_reset");
    floor_passed = 1'b0;
    rst = 1'b1;
    cyc(pk(0,0,0,0,3,0,0), M_ALL, "midgame_reset0");
    cyc(pk(0,0,0,0,3,0,0), M_ALL, "midgame_reset1");
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) cyc(pk(0,0,0,0,3,0,0), M_ALL, $sformatf("held_start_k%0d", k));
    start = 1'b0;
    cyc(pk(0,0,0,0,3,0,0), M_ALL, "start_released");
    start = 1'b1;
    cyc(pk(1,1,0,1,3,0,0), M_ALL, "start_after_release");
    start = 1'b0;
    cyc(pk(1,1,0,0,3,0,0), M_ALL, "clear_once");

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $error("FAIL leftover_queue: observed=%0d expected=0", exp_q.size());
    end

    // Final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
